// File: rtl/check_scan_if.sv
// Beat stream from the check_scan readout engine to a display/UART/trace sink.
// A beat transfers on any rising edge where out_valid and out_ready are both high.
interface check_scan_if #(
  parameter int N  = 64,
  parameter int AW = 8
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [N-1:0]  out_data;
  logic          out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/check_scan.sv
// Debug readout engine: sweeps register file or data memory check ports and streams (addr, data) beats.
// Optional SCAN_CHKSUM_EN appends a rotating-XOR checksum beat at the end of every scan.
module check_scan #(
  parameter int N  = 64,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] count,
  output logic [AW-1:0] checkra,
  input  logic [N-1:0]  checkr,
  output logic [AW-1:0] checkma,
  input  logic [31:0]   checkm,
  check_scan_if.master  stream,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SEND    = 3'd2,
    S_FIN     = 3'd3,
    S_CKLOAD  = 3'd4
  } state_t;

`ifdef SCAN_CHKSUM_EN
  localparam state_t TAIL = S_CKLOAD;
`else
  localparam state_t TAIL = S_FIN;
`endif

  state_t        state;
  state_t        state_nx;
  logic          mode_q;
  logic [CW-1:0] rem;
  logic [AW-1:0] cur;
  logic          hs;
  logic          more;

  assign hs        = (state == S_SEND) && stream.out_ready;
  // Another data entry follows the beat being handed off.
  assign more      = !stream.out_last && (rem != CW'(1));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (count == '0) ? TAIL : S_CAPTURE;
      end
      S_CAPTURE: state_nx = S_SEND;
      S_SEND: begin
        if (hs) begin
          if (stream.out_last) state_nx = S_FIN;
          else if (more)       state_nx = S_CAPTURE;
          else                 state_nx = TAIL;
        end
      end
      S_FIN:    state_nx = S_IDLE;
      S_CKLOAD: state_nx = S_SEND;
      default:  state_nx = S_IDLE;
    endcase
  end

`ifdef SCAN_CHKSUM_EN
  logic [N-1:0] ck;

  always_ff @(posedge clk) begin
    if (reset)                         ck <= '0;
    else if (state == S_IDLE && start) ck <= '0;
    else if (hs && !stream.out_last)   ck <= {ck[N-2:0], ck[N-1]} ^ stream.out_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      checkra          <= '0;
      checkma          <= '0;
      stream.out_addr  <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      mode_q           <= 1'b0;
      rem              <= '0;
      cur              <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            rem    <= count;
            cur    <= base;
            if (mode) checkma <= base;
            else      checkra <= base;
          end
        end
        S_CAPTURE: begin
          stream.out_data  <= mode_q ? {{(N-32){1'b0}}, checkm} : checkr;
          stream.out_addr  <= cur;
`ifdef SCAN_CHKSUM_EN
          stream.out_last  <= 1'b0;
`else
          stream.out_last  <= (rem == CW'(1));
`endif
          stream.out_valid <= 1'b1;
        end
        S_SEND: begin
          if (hs) begin
            stream.out_valid <= 1'b0;
            if (rem != '0) rem <= rem - CW'(1);
            if (more) begin
              cur <= cur + AW'(1);
              if (mode_q) checkma <= cur + AW'(1);
              else        checkra <= cur + AW'(1);
            end
          end
        end
`ifdef SCAN_CHKSUM_EN
        S_CKLOAD: begin
          stream.out_addr  <= '1;
          stream.out_data  <= ck;
          stream.out_last  <= 1'b1;
          stream.out_valid <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_check_scan.sv
// Self-checking bench for check_scan: randomized scans against a queue-based model of the beat stream.
module tb_check_scan;
  localparam int N  = 64;
  localparam int AW = 8;
  localparam int CW = 8;
`ifdef SCAN_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [AW-1:0] base  = '0;
  logic [CW-1:0] count = '0;
  logic [AW-1:0] checkra;
  logic [AW-1:0] checkma;
  logic [N-1:0]  checkr;
  logic [31:0]   checkm;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  logic [N-1:0]  regs [256];
  logic [31:0]   mem  [256];

  check_scan_if #(.N(N), .AW(AW)) sif ();

  assign checkr = regs[checkra];
  assign checkm = mem[checkma];

  check_scan #(.N(N), .AW(AW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .base      (base),
    .count     (count),
    .checkra   (checkra),
    .checkr    (checkr),
    .checkma   (checkma),
    .checkm    (checkm),
    .stream    (sif),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [AW-1:0] exp_addr_q [$];
  logic [N-1:0]  exp_data_q [$];
  logic          exp_last_q [$];
  logic [AW-1:0] log_addr [$];
  logic [N-1:0]  log_data [$];
  logic          log_last [$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            done_exp_cyc = -1;
  bit            scan_active = 0;
  logic [AW-1:0] exp_ra = '0;
  logic [AW-1:0] exp_ma = '0;
  bit            rand_ready = 0;
  int            force_low = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] held_addr;
  logic [N-1:0]  held_data;
  logic          held_last;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sink ready generation
  always @(posedge clk) begin
    #1;
    if (force_low > 0) begin
      sif.out_ready = 1'b0;
      force_low--;
    end else if (rand_ready) sif.out_ready = 1'($urandom_range(0, 1));
    else sif.out_ready = 1'b1;
  end

  // compare process
  always @(negedge clk) begin
    if (reset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_valid", sif.out_valid, 1'b1);
        check("hold_addr", sif.out_addr, held_addr);
        check("hold_data", sif.out_data, held_data);
        check("hold_last", sif.out_last, held_last);
      end
      if (sif.out_valid && exp_addr_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_beat: got addr %h data %h expected no beat (cycle %0d)",
                 sif.out_addr, sif.out_data, cyc);
      end else if (sif.out_valid && sif.out_ready) begin
        check("beat_addr", sif.out_addr, exp_addr_q.pop_front());
        check("beat_data", sif.out_data, exp_data_q.pop_front());
        check("beat_last", sif.out_last, exp_last_q.pop_front());
        log_addr.push_back(sif.out_addr);
        log_data.push_back(sif.out_data);
        log_last.push_back(sif.out_last);
        if (exp_addr_q.size() == 0) done_exp_cyc = cyc + 1;
      end
      check("done", done, N'(cyc == done_exp_cyc));
      check("busy", busy, N'(scan_active));
      if (cyc == done_exp_cyc) scan_active = 0;
      prev_stall = sif.out_valid && !sif.out_ready;
      held_addr  = sif.out_addr;
      held_data  = sif.out_data;
      held_last  = sif.out_last;
    end
  end

  // driver: pulse start and, if the engine is idle, build the expected beat list
  task automatic do_scan(input logic m, input logic [AW-1:0] b, input logic [CW-1:0] c);
    logic [AW-1:0] a;
    logic [AW-1:0] last_a;
    logic [N-1:0]  d;
    logic [N-1:0]  ck;
    int            ci;
    mode  = m;
    base  = b;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!scan_active) begin
      ck     = '0;
      ci     = int'(c);
      last_a = b;
      for (int i = 0; i < ci; i++) begin
        a = b + AW'(i);
        d = m ? {32'h0, mem[a]} : regs[a];
        ck = {ck[N-2:0], ck[N-1]} ^ d;
        last_a = a;
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        exp_last_q.push_back((CHK == 0) && (i == ci - 1));
      end
      if (CHK != 0) begin
        exp_addr_q.push_back('1);
        exp_data_q.push_back(ck);
        exp_last_q.push_back(1'b1);
      end
      if (m) exp_ma = last_a;
      else   exp_ra = last_a;
      scan_active = 1;
      if (exp_addr_q.size() == 0) done_exp_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (scan_active && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (scan_active) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, t);
      scan_active = 0;
    end
    @(negedge clk);
    check({name, "_drained"}, N'(exp_addr_q.size()), '0);
    check({name, "_checkra"}, checkra, exp_ra);
    check({name, "_checkma"}, checkma, exp_ma);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_last.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, sif.out_valid, 1'b0);
    check({name, "_last"}, sif.out_last, 1'b0);
    check({name, "_addr"}, sif.out_addr, '0);
    check({name, "_data"}, sif.out_data, '0);
    check({name, "_checkra"}, checkra, '0);
    check({name, "_checkma"}, checkma, '0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) begin
      regs[i] = {$urandom, $urandom};
      mem[i]  = $urandom;
    end
    for (int i = 0; i < 4; i++) regs[8+i] = N'(i + 1);
    mem[3] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // register scan, ready held high, with latency pin
    clear_log();
    do_scan(1'b0, 8'd8, 8'd4);
    @(negedge clk);
    check("lat_valid_c1", sif.out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid_c2", sif.out_valid, 1'b1);
    wait_idle("reg");
    for (int i = 0; i < 4; i++) begin
      check("reg_addr_lit", log_addr[i], N'(8 + i));
      check("reg_data_lit", log_data[i], N'(i + 1));
      check("reg_last_lit", log_last[i], N'((CHK == 0) && (i == 3)));
    end
    check("reg_nbeats_lit", N'(log_addr.size()), N'(4 + CHK));

    // memory scan leaves checkra alone
    clear_log();
    do_scan(1'b1, 8'd3, 8'd1);
    wait_idle("mem");
    check("mem_addr_lit", log_addr[0], 8'd3);
    check("mem_data_lit", log_data[0], 64'h00000000DEADBEEF);
    check("mem_last_lit", log_last[0], N'(CHK == 0));
    check("mem_checkra_lit", checkra, 8'd11);

    // backpressure on beat 2
    clear_log();
    do_scan(1'b0, 8'd20, 8'd4);
    t = 0;
    while (log_addr.size() < 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    force_low = 5;
    wait_idle("bp");
    check("bp_nbeats_lit", N'(log_addr.size()), N'(4 + CHK));

    // address wrap with an ignored mid-scan start
    clear_log();
    do_scan(1'b0, 8'hFE, 8'd3);
    @(negedge clk);
    do_scan(1'b1, 8'd5, 8'd7);
    wait_idle("wrap");
    check("wrap_addr0_lit", log_addr[0], 8'hFE);
    check("wrap_addr1_lit", log_addr[1], 8'hFF);
    check("wrap_addr2_lit", log_addr[2], 8'h00);

    // zero count
    clear_log();
    do_scan(1'b0, 8'd40, 8'd0);
    wait_idle("zero");
    check("zero_nbeats_lit", N'(log_addr.size()), N'(CHK));

    // reset while a beat is stalled in SEND
    force_low = 1000;
    do_scan(1'b0, 8'd50, 8'd5);
    t = 0;
    while (!sif.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_pre_valid", sif.out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    scan_active  = 0;
    done_exp_cyc = -1;
    exp_ra       = '0;
    exp_ma       = '0;
    reset        = 1'b0;
    force_low    = 0;
    repeat (5) @(negedge clk);

    // randomized scans with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      do_scan(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), CW'($urandom_range(0, 12)));
      wait_idle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
